qos_deserializer: RTL and testbench

Per-VC serial-to-parallel reassembly stage that sits directly downstream of the QoS output mux. Each cycle it samples the mux's serial `data_out` bit together with the `VC_id` granted by the weighted-round-robin arbiter. It accumulates bits into a separate word for each of the four virtual channels. Completed words are queued, tagged with their VC, in a small output FIFO drained through a valid/ready handshake.

---
 rtl/qos_deserializer.sv | 130 +++++++++++++
 tb/tb_qos_deserializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/qos_deserializer.sv
// Per-VC serial-to-parallel reassembly with a VC-tagged show-ahead output FIFO.
// Optional even-parity framing is built when QOS_DESER_PARITY_EN is defined.
module qos_deserializer #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_out,
  input  logic [1:0]                    VC_id,
  input  logic                          bit_valid,
  output logic [WORD_W-1:0]             word_out,
  output logic [1:0]                    word_vc,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          parity_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

`ifdef QOS_DESER_PARITY_EN
  localparam int FRAME = WORD_W + 1;
`else
  localparam int FRAME = WORD_W;
`endif
  localparam int CW = $clog2(FRAME);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [4*WORD_W-1:0] sr_all;
  logic [4*CW-1:0]     cnt_all;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_vc
      logic [WORD_W-1:0] sr_reg;
      logic [CW-1:0]     cnt_reg;
      logic              hit;

      assign hit = bit_valid && (VC_id == 2'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sr_reg  <= '0;
          cnt_reg <= '0;
        end else if (hit) begin
          // Parity bit position (cnt == WORD_W) matches no data slot.
          for (int j = 0; j < WORD_W; j++) begin
            if (cnt_reg == CW'(j)) sr_reg[j] <= data_out;
          end
          cnt_reg <= (cnt_reg == CW'(FRAME - 1)) ? '0 : cnt_reg + 1'b1;
        end
      end

      assign sr_all[gi*WORD_W +: WORD_W] = sr_reg;
      assign cnt_all[gi*CW +: CW]        = cnt_reg;
    end
  endgenerate

  logic [WORD_W-1:0] sr_sel;
  logic [CW-1:0]     cnt_sel;
  logic [WORD_W-1:0] cur_word;
  logic              complete;

  assign sr_sel   = sr_all[32'(VC_id)*WORD_W +: WORD_W];
  assign cnt_sel  = cnt_all[32'(VC_id)*CW +: CW];
  assign complete = bit_valid && (cnt_sel == CW'(FRAME - 1));

`ifdef QOS_DESER_PARITY_EN
  logic cur_par;
  assign cur_word = sr_sel;
  assign cur_par  = (^sr_sel) ^ data_out;
`else
  // The final data bit is still on the wire; merge it into the assembled word.
  always_comb begin
    cur_word           = sr_sel;
    cur_word[WORD_W-1] = data_out;
  end
`endif

  logic [WORD_W-1:0] data_mem [FIFO_DEPTH];
  logic [1:0]        vc_mem   [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]       count_reg;
  logic              overflow_reg;
  logic              full, pop, push;

  assign full = (count_reg == (PW+1)'(FIFO_DEPTH));
  assign pop  = (count_reg != '0) && word_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push = complete && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= cur_word;
      vc_mem[wr_ptr_reg]   <= VC_id;
    end
  end

`ifdef QOS_DESER_PARITY_EN
  logic par_mem [FIFO_DEPTH];
  always_ff @(posedge clk) begin
    if (push) par_mem[wr_ptr_reg] <= cur_par;
  end
  assign parity_err = word_valid && par_mem[rd_ptr_reg];
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      if (complete && full && !pop) overflow_reg <= 1'b1;
    end
  end

  assign word_valid = (count_reg != '0);
  assign word_out   = word_valid ? data_mem[rd_ptr_reg] : '0;
  assign word_vc    = word_valid ? vc_mem[rd_ptr_reg]   : 2'd0;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_qos_deserializer.sv
// Scoreboard bench for qos_deserializer: expected words queued at drive time,
// compared by a monitor whenever the DUT hands over a word.
module tb_qos_deserializer;
  localparam int WORD_W = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              data_out = 1'b0;
  logic [1:0]        VC_id = 2'd0;
  logic              bit_valid = 1'b0;
  logic              word_ready = 1'b0;
  logic [WORD_W-1:0] word_out;
  logic [1:0]        word_vc;
  logic              word_valid;
  logic              parity_err;
  logic [2:0]        fifo_count;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]        vc;
    logic [WORD_W-1:0] w;
    logic              p;
  } exp_t;
  exp_t exp_q[$];

  qos_deserializer #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .data_out(data_out), .VC_id(VC_id),
    .bit_valid(bit_valid), .word_out(word_out), .word_vc(word_vc),
    .word_valid(word_valid), .word_ready(word_ready), .parity_err(parity_err),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Handshake monitor: inputs change at posedge+1, so negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (reset && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_data",   32'(word_out),   32'(e.w));
        check("pop_vc",     32'(word_vc),    32'(e.vc));
        check("pop_parity", 32'(parity_err), 32'(e.p));
      end
    end
  end

  task automatic send_bit(input logic [1:0] vc, input logic b);
    VC_id = vc; data_out = b; bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic expect_word(input logic [1:0] vc, input logic [WORD_W-1:0] w, input logic flip);
    exp_t e;
    e.vc = vc; e.w = w;
`ifdef QOS_DESER_PARITY_EN
    e.p = flip;
`else
    e.p = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  // Data bits LSB first; with parity enabled a trailing even-parity bit (optionally flipped).
  task automatic send_word(input logic [1:0] vc, input logic [WORD_W-1:0] w, input logic flip);
    for (int i = 0; i < WORD_W; i++) send_bit(vc, w[i]);
`ifdef QOS_DESER_PARITY_EN
    send_bit(vc, (^w) ^ flip);
`else
    if (flip) begin end
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    check("rst_valid",    32'(word_valid), 0);
    check("rst_count",    32'(fifo_count), 0);
    check("rst_overflow", 32'(overflow),   0);
    check("rst_word",     32'(word_out),   0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    word_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    word_ready = 1'b0;
    check({tag, "_drained"}, 32'(exp_q.size()), 0);
    check({tag, "_empty"},   32'(word_valid),   0);
  endtask

  initial begin
    logic [WORD_W-1:0] a = 8'h0F;
    logic [WORD_W-1:0] b = 8'hF0;

    #2;
    do_reset();

    // Single word on VC 1
    expect_word(2'd1, 8'hA5, 1'b0);
    send_word(2'd1, 8'hA5, 1'b0);
    check("t1_valid", 32'(word_valid), 1);
    check("t1_word",  32'(word_out),   32'hA5);
    check("t1_vc",    32'(word_vc),    1);
    check("t1_count", 32'(fifo_count), 1);
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    check("t1_popped", 32'(word_valid), 0);

    // Interleaved VC 0 / VC 2
    word_ready = 1'b1;
    expect_word(2'd0, a, 1'b0);
    expect_word(2'd2, b, 1'b0);
    for (int i = 0; i < WORD_W; i++) begin
      send_bit(2'd0, a[i]);
      send_bit(2'd2, b[i]);
    end
`ifdef QOS_DESER_PARITY_EN
    send_bit(2'd0, ^a);
    send_bit(2'd2, ^b);
`endif
    drain("t2");

    // Gap tolerance on VC 3
    expect_word(2'd3, 8'h6B, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(2'd3, a[0] ^ a[0] ^ 1'(8'h6B >> i));
    repeat (10) begin @(posedge clk); #1; end
    check("t3_gap_nothing", 32'(word_valid), 0);
    for (int i = 3; i < WORD_W; i++) send_bit(2'd3, 1'(8'h6B >> i));
`ifdef QOS_DESER_PARITY_EN
    send_bit(2'd3, ^(8'h6B));
`endif
    check("t3_valid", 32'(word_valid), 1);
    drain("t3");

    // Overflow: five words into a four-entry FIFO
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) expect_word(2'd0, 8'(k * 8'h11), 1'b0);
      send_word(2'd0, 8'(k * 8'h11), 1'b0);
    end
    check("t4_count",    32'(fifo_count), 4);
    check("t4_overflow", 32'(overflow),   1);
    drain("t4");
    check("t4_sticky",   32'(overflow),   1);

    // Full FIFO, push coincides with pop
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      expect_word(2'd1, 8'(k * 8'h21), 1'b0);
      send_word(2'd1, 8'(k * 8'h21), 1'b0);
    end
    check("t5_full", 32'(fifo_count), 4);
    expect_word(2'd3, 8'hC7, 1'b0);
    for (int i = 0; i < FRAME_BITS() - 1; i++) send_bit(2'd3, frame_bit(8'hC7, i, 1'b0));
    word_ready = 1'b1;
    send_bit(2'd3, frame_bit(8'hC7, FRAME_BITS() - 1, 1'b0));
    word_ready = 1'b0;
    check("t5_count",    32'(fifo_count), 4);
    check("t5_overflow", 32'(overflow),   0);
    drain("t5");

    // Reset mid-word, then a clean word
    for (int i = 0; i < 5; i++) send_bit(2'd2, 1'b1);
    do_reset();
    expect_word(2'd2, 8'h3C, 1'b1);
    send_word(2'd2, 8'h3C, 1'b1);
    check("t6_word", 32'(word_out), 32'h3C);
`ifdef QOS_DESER_PARITY_EN
    check("t6_perr1", 32'(parity_err), 1);
`else
    check("t6_perr_tied", 32'(parity_err), 0);
`endif
    drain("t6a");
    expect_word(2'd2, 8'h3C, 1'b0);
    send_word(2'd2, 8'h3C, 1'b0);
    check("t6_perr0", 32'(parity_err), 0);
    drain("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic int FRAME_BITS();
`ifdef QOS_DESER_PARITY_EN
    return WORD_W + 1;
`else
    return WORD_W;
`endif
  endfunction

  function automatic logic frame_bit(input logic [WORD_W-1:0] w, input int i, input logic flip);
    if (i < WORD_W) return w[i];
    return (^w) ^ flip;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
